// File: rtl/multi_lifo_pkg.sv
// Shared helpers and types for the multi-channel LIFO.
// Optional error flags are built in when MULTI_LIFO_ERR_EN is defined.
package multi_lifo_pkg;

    // Wide enough for any count this design is expected to hold
    localparam int CNT_MAX_W = 16;

    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [CNT_MAX_W-1:0] count;
        logic                 empty;
        logic                 full;
    } ch_state_t;

endpackage

// File: rtl/multi_lifo_if.sv
// Request/response bundle of multi_lifo.
// Error ports exist only when MULTI_LIFO_ERR_EN is defined.
interface multi_lifo_if
    import multi_lifo_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic                  push_i;
    logic [CH_W-1:0]       push_ch_i;
    logic [DATA_WIDTH-1:0] push_data_i;
    logic                  pop_i;
    logic [CH_W-1:0]       pop_ch_i;
    logic [DATA_WIDTH-1:0] pop_data_o;
    logic [CNT_W-1:0]      count_o;
    logic [NUM_CH-1:0]     empty_o;
    logic [NUM_CH-1:0]     full_o;
`ifdef MULTI_LIFO_ERR_EN
    logic                  err_clr_i;
    logic [NUM_CH-1:0]     ovf_o;
    logic [NUM_CH-1:0]     udf_o;
`endif

    modport master (
`ifdef MULTI_LIFO_ERR_EN
        output err_clr_i,
        input  ovf_o, udf_o,
`endif
        output push_i, push_ch_i, push_data_i, pop_i, pop_ch_i,
        input  pop_data_o, count_o, empty_o, full_o
    );

    modport slave (
`ifdef MULTI_LIFO_ERR_EN
        input  err_clr_i,
        output ovf_o, udf_o,
`endif
        input  push_i, push_ch_i, push_data_i, pop_i, pop_ch_i,
        output pop_data_o, count_o, empty_o, full_o
    );

endinterface

// File: rtl/multi_lifo_ch_ctrl.sv
// Per-stack occupancy, pointer and flag control for multi_lifo.
// Sticky overflow/underflow flags are added when MULTI_LIFO_ERR_EN is defined.
module lifo_ch_ctrl
    import multi_lifo_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = cnt_w(DEPTH),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_sel,
    input  logic             pop_sel,
`ifdef MULTI_LIFO_ERR_EN
    input  logic             err_clr,
    output logic             ovf,
    output logic             udf,
`endif
    output logic             push_ok,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    ch_state_t            st_q;
    logic [CNT_MAX_W-1:0] cnt_nxt;
    logic                 pop_ok;

    // A same-channel pop makes room, so a push to a full stack becomes a replace
    assign pop_ok  = pop_sel && !st_q.empty;
    assign push_ok = push_sel && (!st_q.full || pop_sel);
    assign rd_ptr  = PTR_W'(st_q.count - CNT_MAX_W'(1));
    assign wr_ptr  = pop_ok ? rd_ptr : PTR_W'(st_q.count);

    always_comb begin
        cnt_nxt = st_q.count;
        if (push_ok && !pop_ok)
            cnt_nxt = st_q.count + CNT_MAX_W'(1);
        else if (pop_ok && !push_ok)
            cnt_nxt = st_q.count - CNT_MAX_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q.count <= '0;
            st_q.empty <= 1'b1;
            st_q.full  <= 1'b0;
        end else begin
            st_q.count <= cnt_nxt;
            st_q.empty <= (cnt_nxt == '0);
            st_q.full  <= (cnt_nxt == CNT_MAX_W'(DEPTH));
        end
    end

    assign count = CNT_W'(st_q.count);
    assign empty = st_q.empty;
    assign full  = st_q.full;

`ifdef MULTI_LIFO_ERR_EN
    // A new drop in the clearing cycle keeps the flag set
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (ovf && !err_clr) || (push_sel && !push_ok);
            udf <= (udf && !err_clr) || (pop_sel && !pop_ok);
        end
    end
`endif

endmodule

// File: rtl/multi_lifo.sv
// NUM_CH independent stacks sharing one storage array addressed by {ch, ptr}.
// Define MULTI_LIFO_ERR_EN to add err_clr_i / ovf_o / udf_o.
module multi_lifo
    import multi_lifo_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEPTH           = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int OUTPUT_REGISTER = 0
) (
    input logic         clk_i,
    input logic         reset_i,
    multi_lifo_if.slave bus
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int AW    = CH_W + PTR_W;

    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

    logic [NUM_CH-1:0]             push_sel, pop_sel, push_ok, empty, full;
    logic [NUM_CH-1:0][PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0]  count;
`ifdef MULTI_LIFO_ERR_EN
    logic [NUM_CH-1:0]             ovf, udf;
`endif

    logic [PTR_W-1:0]      wr_ptr_sel, rd_ptr_sel;
    logic [CNT_W-1:0]      count_sel;
    logic                  ch_hit;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] peek;

    // Channel indices >= NUM_CH select nothing and are therefore dropped
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push_sel[c] = bus.push_i && (bus.push_ch_i == CH_W'(c));
        assign pop_sel[c]  = bus.pop_i  && (bus.pop_ch_i  == CH_W'(c));

        lifo_ch_ctrl #(.DEPTH(DEPTH)) u_ctrl (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .push_sel(push_sel[c]),
            .pop_sel (pop_sel[c]),
`ifdef MULTI_LIFO_ERR_EN
            .err_clr (bus.err_clr_i),
            .ovf     (ovf[c]),
            .udf     (udf[c]),
`endif
            .push_ok (push_ok[c]),
            .wr_ptr  (wr_ptr[c]),
            .rd_ptr  (rd_ptr[c]),
            .count   (count[c]),
            .empty   (empty[c]),
            .full    (full[c])
        );
    end

    always_comb begin
        wr_ptr_sel = '0;
        rd_ptr_sel = '0;
        count_sel  = '0;
        ch_hit     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.push_ch_i == CH_W'(c))
                wr_ptr_sel = wr_ptr[c];
            if (bus.pop_ch_i == CH_W'(c)) begin
                rd_ptr_sel = rd_ptr[c];
                count_sel  = count[c];
                ch_hit     = 1'b1;
            end
        end
    end

    assign wr_en   = (|push_ok) && !reset_i;
    assign wr_addr = {bus.push_ch_i, wr_ptr_sel};
    assign rd_addr = {bus.pop_ch_i, rd_ptr_sel};
    assign peek    = ch_hit ? mem[rd_addr] : '0;

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_addr] <= bus.push_data_i;
    end

    if (OUTPUT_REGISTER != 0) begin : g_reg
        logic [DATA_WIDTH-1:0] pop_q;
        // Read happens before the same-edge replace write, so the old top is captured
        always_ff @(posedge clk_i) begin
            if (reset_i)
                pop_q <= '0;
            else if (|(pop_sel & ~empty))
                pop_q <= peek;
        end
        assign bus.pop_data_o = pop_q;
    end else begin : g_comb
        assign bus.pop_data_o = peek;
    end

    assign bus.count_o = count_sel;
    assign bus.empty_o = empty;
    assign bus.full_o  = full;
`ifdef MULTI_LIFO_ERR_EN
    assign bus.ovf_o   = ovf;
    assign bus.udf_o   = udf;
`endif

endmodule
